// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: datapath width, NOP encoding,
// default reset vector and the fetch buffer entry layout.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer between fetch and decode. Flush empties it in one
// edge; the head entry is read combinationally from storage.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t push_entry,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing with redirect and a 2-entry buffer that
// decouples the instruction memory from decode back-pressure.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        misalign_err
);

    logic [31:0]  pc;
    logic         pop;
    logic         push;
    logic         full;
    logic         empty;
    fetch_entry_t head;
    fetch_entry_t push_entry;

    // Reset masks the outputs combinationally so nothing stale leaks out
    // during the reset cycle itself.
    assign out_valid = !empty && !rst;
    assign out_instr = out_valid ? head.instr : NOP_INSTR;
    assign out_pc    = out_valid ? head.pc : 32'h0;
    assign imem_addr = rst ? RESET_PC : pc;

    assign pop  = out_valid && out_ready;
    assign push = fetch_en && !redirect_valid && !rst && (!full || pop);

    assign push_entry.pc    = pc;
    assign push_entry.instr = imem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= RESET_PC;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) begin
                pc <= {redirect_pc[31:2], 2'b00};
            end else if (push) begin
                pc <= pc + 32'd4;
            end
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (push),
        .pop        (pop),
        .push_entry (push_entry),
        .head       (head),
        .full       (full),
        .empty      (empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one task per scenario with hand-computed
// expectations; a second instance covers PC wrap-around.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;

    logic [31:0] imem_addr,  imem_rdata;
    logic        out_valid,  misalign_err;
    logic [31:0] out_instr,  out_pc;

    logic [31:0] w_imem_addr, w_imem_rdata;
    logic        w_out_valid, w_misalign_err;
    logic [31:0] w_out_instr, w_out_pc;

    int checks;
    int failures;

    // Memory word at each address is its word index.
    assign imem_rdata   = {2'b00, imem_addr[31:2]};
    assign w_imem_rdata = {2'b00, w_imem_addr[31:2]};

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .misalign_err   (misalign_err)
    );

    fetch_unit #(
        .RESET_PC(32'hFFFF_FFF8)
    ) dut_wrap (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (w_imem_addr),
        .imem_rdata     (w_imem_rdata),
        .out_valid      (w_out_valid),
        .out_ready      (out_ready),
        .out_instr      (w_out_instr),
        .out_pc         (w_out_pc),
        .misalign_err   (w_misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        fetch_en       = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        fetch_en       = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0302;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_valid got=%0b exp=0", out_valid);
        end
        checks++;
        if (out_instr !== 32'h0000_0013) begin
            failures++;
            $display("[TB] FAIL reset_instr got=%h exp=00000013", out_instr);
        end
        checks++;
        if (out_pc !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_pc got=%h exp=00000000", out_pc);
        end
        checks++;
        if (imem_addr !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_imem_addr got=%h exp=00000000", imem_addr);
        end
        checks++;
        if (misalign_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_misalign got=%0b exp=0", misalign_err);
        end
        checks++;
        if (w_imem_addr !== 32'hFFFF_FFF8) begin
            failures++;
            $display("[TB] FAIL reset_wrap_addr got=%h exp=fffffff8", w_imem_addr);
        end
    endtask

    task automatic test_stream();
        do_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stream_latency got=%0b exp=0", out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_instr !== 32'(i)) begin
                failures++;
                $display("[TB] FAIL stream_%0d got v=%0b pc=%h instr=%h exp v=1 pc=%h instr=%h",
                         i, out_valid, out_pc, out_instr, 32'(i * 4), 32'(i));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
                failures++;
                $display("[TB] FAIL stall_hold_%0d got v=%0b pc=%h instr=%h exp v=1 pc=0 instr=0",
                         i, out_valid, out_pc, out_instr);
            end
        end
        checks++;
        if (imem_addr !== 32'h8) begin
            failures++;
            $display("[TB] FAIL stall_pc got=%h exp=00000008", imem_addr);
        end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_instr !== 32'(i)) begin
                failures++;
                $display("[TB] FAIL stall_resume_%0d got v=%0b pc=%h instr=%h exp pc=%h",
                         i, out_valid, out_pc, out_instr, 32'(i * 4));
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b0;
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        out_ready      = 1'b1;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_instr !== 32'h13 || out_pc !== 32'h0) begin
            failures++;
            $display("[TB] FAIL redirect_flush got v=%0b pc=%h instr=%h exp v=0 pc=0 instr=13",
                     out_valid, out_pc, out_instr);
        end
        checks++;
        if (imem_addr !== 32'h100 || misalign_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL redirect_target got addr=%h mis=%0b exp addr=100 mis=0",
                     imem_addr, misalign_err);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== 32'h40) begin
            failures++;
            $display("[TB] FAIL redirect_first got v=%0b pc=%h instr=%h exp v=1 pc=100 instr=40",
                     out_valid, out_pc, out_instr);
        end
        step();
        checks++;
        if (out_pc !== 32'h104 || out_instr !== 32'h41) begin
            failures++;
            $display("[TB] FAIL redirect_second got pc=%h instr=%h exp pc=104 instr=41",
                     out_pc, out_instr);
        end
    endtask

    task automatic test_misalign();
        do_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (misalign_err !== 1'b1 || imem_addr !== 32'h100) begin
            failures++;
            $display("[TB] FAIL misalign_pulse got mis=%0b addr=%h exp mis=1 addr=100",
                     misalign_err, imem_addr);
        end
        step();
        checks++;
        if (misalign_err !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h100) begin
            failures++;
            $display("[TB] FAIL misalign_after got mis=%0b v=%0b pc=%h exp mis=0 v=1 pc=100",
                     misalign_err, out_valid, out_pc);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8;
        exp_pc[1] = 32'hFFFF_FFFC;
        exp_pc[2] = 32'h0000_0000;
        do_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (w_out_valid !== 1'b1 || w_out_pc !== exp_pc[i]) begin
                failures++;
                $display("[TB] FAIL wrap_%0d got v=%0b pc=%h exp v=1 pc=%h",
                         i, w_out_valid, w_out_pc, exp_pc[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        fetch_en       = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        checks++;
        if (out_pc !== 32'h200) begin
            failures++;
            $display("[TB] FAIL midreset_setup got pc=%h exp pc=200", out_pc);
        end
        rst = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_instr !== 32'h13 || imem_addr !== 32'h0) begin
            failures++;
            $display("[TB] FAIL midreset_clear got v=%0b instr=%h addr=%h exp v=0 instr=13 addr=0",
                     out_valid, out_instr, imem_addr);
        end
        rst = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
            failures++;
            $display("[TB] FAIL midreset_first got v=%0b pc=%h instr=%h exp v=1 pc=0 instr=0",
                     out_valid, out_pc, out_instr);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_pc !== 32'h4) begin
            failures++;
            $display("[TB] FAIL midreset_second got pc=%h exp pc=4", out_pc);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_misalign();
        test_wrap();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
